hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives stall_*/flush_* into PC, IF_ID, ID_EX, EX_MEM and MEM_WB. Three hazard sources are handled in priority order:
- multi-cycle data-memory access, sequenced by a req/ack FSM;
- load-use data hazards;
- taken-branch control hazards.

It also provides a memory timeout error and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 255: max cycles in MEM_REQ before entering ERROR; legal range 1..65535.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- exmem_mem_access_i  in  1  EX_MEM holds a load or store.
- dmem_ack_i  in  1  data memory completes access this cycle.
- dmem_req_o  out  1  request to data memory.
- idex_memread_i  in  1  ID_EX holds a load.
- idex_rd_i  in  5  load destination register.
- ifid_rs1_i  in  5  source register 1 of the IF_ID instruction.
- ifid_rs2_i  in  5  source register 2 of the IF_ID instruction.
- branch_taken_i  in  1  branch resolved taken in ID.
- stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o, stall_memwb_o  out  1 each  stall outputs.
- flush_ifid_o, flush_idex_o, flush_memwb_o  out  1 each  flush outputs.
- error_o  out  1  memory timeout, sticky.
- stall_cnt_o  out  CNT_W  count of cycles with stall_pc_o=1, saturating.

Behaviour:
- States are IDLE, MEM_REQ and ERROR, encoded in 2 bits. Reset puts the FSM in IDLE, the timeout counter at 0, error_o at 0 and stall_cnt_o at 0.
- While rst_i=0, every stall_*, flush_* and dmem_req_o output is forced to 0.
- All stall/flush outputs are combinational from the current state and the inputs. There are no registered outputs except error_o and stall_cnt_o.
- IDLE:
  - If exmem_mem_access_i=1: assert all five stall_* and flush_memwb_o (MEM_WB receives a bubble), keep dmem_req_o=0, go to MEM_REQ, clear the timeout counter.
  - Otherwise, if load-use: stall_pc_o=1, stall_ifid_o=1, flush_idex_o=1, flush_ifid_o=0. Branch is ignored this cycle and re-evaluated next cycle.
    - Load-use condition: idex_memread_i=1 and idex_rd_i!=0 and (idex_rd_i==ifid_rs1_i or idex_rd_i==ifid_rs2_i).
  - Otherwise, if branch_taken_i=1: flush_ifid_o=1.
  - Otherwise all outputs are 0.
- MEM_REQ:
  - dmem_req_o=1.
  - If dmem_ack_i=0: all five stall_* high, flush_memwb_o=1, timeout counter +1.
    - When the counter reaches MEM_TIMEOUT, go to ERROR.
  - If dmem_ack_i=1: drop all stalls and flush_memwb_o so the pipeline advances on this edge, and return to IDLE.
    - Load-use and branch rules from IDLE are applied in the same cycle.
- Minimum memory-op cost is 2 cycles: 1 detect cycle plus 1 ack cycle. A back-to-back memory op is detected again in IDLE on the next cycle.
- ERROR:
  - All stall_* high, flush_memwb_o=1, dmem_req_o=0, error_o=1.
  - Stays in ERROR until reset. dmem_ack_i is ignored.
- Priority: memory stall > load-use > branch flush.
  - While any memory stall is active, flush_ifid_o=0 and flush_idex_o=0. A stall held in a register overrides its flush anyway; driving the flushes to 0 keeps the outputs clean.
- stall_cnt_o increments on every cycle with stall_pc_o=1 and saturates at all-ones.
- Asynchronous reset mid-MEM_REQ: the FSM returns to IDLE immediately, dmem_req_o drops, and an outstanding ack is ignored.

Test Plan:
1. Load-use hazard.
   - Stimulus: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5, no mem access.
   - Required: stall_pc/stall_ifid/flush_idex=1 for exactly that cycle; stall_cnt_o 0->1.
   - Repeat with idex_rd_i=0: no stall.
2. Single-ack memory access.
   - Stimulus: exmem_mem_access_i=1 in cycle 0; dmem_ack_i=1 in cycle 1.
   - Required:
     - cycle 0: all stalls=1, dmem_req_o=0;
     - cycle 1: dmem_req_o=1, stalls=0;
     - cycle 2: IDLE.
3. Delayed ack.
   - Stimulus: ack arrives 3 cycles after MEM_REQ entry.
   - Required: dmem_req_o held high for 4 cycles; flush_memwb_o=1 throughout the wait; stall_cnt_o=4 at the end.
4. Simultaneous hazards.
   - Stimulus: load-use and branch_taken_i in the same IDLE cycle.
     - Required: flush_ifid_o=0, load-use stall asserted.
   - Stimulus: mem access with a simultaneous load-use.
     - Required: only memory stalls asserted, flush_idex_o=0.
5. Timeout.
   - Stimulus: MEM_TIMEOUT=4, ack never arrives.
   - Required: error_o=1 after 4 MEM_REQ cycles; stalls stay high; a later dmem_ack_i has no effect; rst_i low clears to IDLE.
6. Reset mid-access.
   - Stimulus: drop rst_i during MEM_REQ.
   - Required: dmem_req_o=0 and all stalls=0 immediately (asynchronous); stall_cnt_o=0; normal operation after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles every pipeline-facing signal of the hazard controller.
//   master : pipeline side. It drives hazard sources and memory ack, and it
//            consumes the stall/flush/request/status outputs.
//   slave  : hazard controller side.
//   Signals:
//     exmem_mem_access_i  EX_MEM holds a load or store
//     dmem_ack_i          data memory completes access this cycle
//     dmem_req_o          request to data memory
//     idex_memread_i      ID_EX holds a load
//     idex_rd_i           load destination register
//     ifid_rs1_i/rs2_i    source registers of the IF_ID instruction
//     branch_taken_i      branch resolved taken in ID
//     stall_*_o           per-register stall enables
//     flush_*_o           per-register bubble inserts
//     error_o             sticky memory timeout
//     stall_cnt_o         saturating count of stall_pc_o cycles
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             exmem_mem_access_i;
  logic             dmem_ack_i;
  logic             dmem_req_o;
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic [4:0]       ifid_rs1_i;
  logic [4:0]       ifid_rs2_i;
  logic             branch_taken_i;
  logic             stall_pc_o;
  logic             stall_ifid_o;
  logic             stall_idex_o;
  logic             stall_exmem_o;
  logic             stall_memwb_o;
  logic             flush_ifid_o;
  logic             flush_idex_o;
  logic             flush_memwb_o;
  logic             error_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output exmem_mem_access_i, dmem_ack_i, idex_memread_i, idex_rd_i,
           ifid_rs1_i, ifid_rs2_i, branch_taken_i,
    input  dmem_req_o, stall_pc_o, stall_ifid_o, stall_idex_o,
           stall_exmem_o, stall_memwb_o, flush_ifid_o, flush_idex_o,
           flush_memwb_o, error_o, stall_cnt_o
  );

  modport slave (
    input  exmem_mem_access_i, dmem_ack_i, idex_memread_i, idex_rd_i,
           ifid_rs1_i, ifid_rs2_i, branch_taken_i,
    output dmem_req_o, stall_pc_o, stall_ifid_o, stall_idex_o,
           stall_exmem_o, stall_memwb_o, flush_ifid_o, flush_idex_o,
           flush_memwb_o, error_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline.
//   Priority: multi-cycle memory access > load-use hazard > taken branch.
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  asynchronous active-low reset
//     bus    hazard_ctrl_if.slave (hazard sources, memory handshake,
//            stall/flush outputs, error_o, stall_cnt_o)
//   Parameters:
//     MEM_TIMEOUT  max MEM_REQ wait cycles before ERROR (1..65535)
//     CNT_W        stall-cycle counter width
//   Stall/flush/request outputs are combinational from state and inputs;
//   error_o and stall_cnt_o are registered.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    ERROR   = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [15:0]      to_cnt;
  logic             error_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic load_use;
  logic mem_stall;
  logic lu_stall;
  logic br_flush;
  logic req;

  assign load_use = bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
                    ((bus.idex_rd_i == bus.ifid_rs1_i) ||
                     (bus.idex_rd_i == bus.ifid_rs2_i));

  // Hazard classification; each class is exclusive so lower-priority
  // flushes are never raised together with a higher-priority stall.
  always_comb begin
    mem_stall = 1'b0;
    lu_stall  = 1'b0;
    br_flush  = 1'b0;
    req       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.exmem_mem_access_i) mem_stall = 1'b1;
        else if (load_use)          lu_stall  = 1'b1;
        else if (bus.branch_taken_i) br_flush = 1'b1;
      end
      MEM_REQ: begin
        req = 1'b1;
        // On the ack cycle the pipeline advances, so the normal
        // load-use/branch rules apply; a new memory op is picked up in IDLE.
        if (!bus.dmem_ack_i)         mem_stall = 1'b1;
        else if (load_use)           lu_stall  = 1'b1;
        else if (bus.branch_taken_i) br_flush  = 1'b1;
      end
      ERROR: mem_stall = 1'b1;
      default: ;
    endcase
  end

  // rst_i gating keeps outputs quiet even though IDLE still decodes inputs.
  assign bus.dmem_req_o    = rst_i & req;
  assign bus.stall_pc_o    = rst_i & (mem_stall | lu_stall);
  assign bus.stall_ifid_o  = rst_i & (mem_stall | lu_stall);
  assign bus.stall_idex_o  = rst_i & mem_stall;
  assign bus.stall_exmem_o = rst_i & mem_stall;
  assign bus.stall_memwb_o = rst_i & mem_stall;
  assign bus.flush_ifid_o  = rst_i & br_flush;
  assign bus.flush_idex_o  = rst_i & lu_stall;
  assign bus.flush_memwb_o = rst_i & mem_stall;
  assign bus.error_o       = error_q;
  assign bus.stall_cnt_o   = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      to_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.exmem_mem_access_i) begin
            state  <= MEM_REQ;
            to_cnt <= '0;
          end
        end
        MEM_REQ: begin
          if (bus.dmem_ack_i) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (to_cnt == TO_LAST) begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
        end
        ERROR: error_q <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (bus.stall_pc_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W(32)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  // {pc, ifid, idex, exmem, memwb}
  logic [4:0] stalls;
  // {ifid, idex, memwb}
  logic [2:0] flushes;
  assign stalls  = {bus.stall_pc_o, bus.stall_ifid_o, bus.stall_idex_o,
                    bus.stall_exmem_o, bus.stall_memwb_o};
  assign flushes = {bus.flush_ifid_o, bus.flush_idex_o, bus.flush_memwb_o};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.exmem_mem_access_i = 1'b0;
    bus.dmem_ack_i         = 1'b0;
    bus.idex_memread_i     = 1'b0;
    bus.idex_rd_i          = 5'd0;
    bus.ifid_rs1_i         = 5'd0;
    bus.ifid_rs2_i         = 5'd0;
    bus.branch_taken_i     = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_i = 1'b0;
    #3;
    rst_i = 1'b1;
    next();
  endtask

  task automatic check_outs(input string tag, input logic [4:0] s,
                            input logic [2:0] f, input logic r);
    check({tag, "_stall"}, 32'(stalls), 32'(s));
    check({tag, "_flush"}, 32'(flushes), 32'(f));
    check({tag, "_req"}, 32'(bus.dmem_req_o), 32'(r));
  endtask

  initial begin
    // Reset: outputs forced low even with a pending mem access
    clear_inputs();
    rst_i = 1'b0;
    bus.exmem_mem_access_i = 1'b1;
    #1;
    check_outs("rst_forced", 5'b00000, 3'b000, 1'b0);
    check("rst_err", 32'(bus.error_o), 32'd0);
    check("rst_cnt", bus.stall_cnt_o, 32'd0);
    bus.exmem_mem_access_i = 1'b0;
    #2;
    rst_i = 1'b1;
    next();
    check_outs("idle", 5'b00000, 3'b000, 1'b0);

    // 1. Load-use on rs2
    bus.idex_memread_i = 1'b1;
    bus.idex_rd_i      = 5'd5;
    bus.ifid_rs2_i     = 5'd5;
    #1;
    check_outs("lu_rs2", 5'b11000, 3'b010, 1'b0);
    check("lu_cnt0", bus.stall_cnt_o, 32'd0);
    next();
    check("lu_cnt1", bus.stall_cnt_o, 32'd1);
    bus.idex_memread_i = 1'b0;
    #1;
    check_outs("lu_gone", 5'b00000, 3'b000, 1'b0);
    // rd = x0 never hazards, even though rs2 = 0 matches
    bus.idex_memread_i = 1'b1;
    bus.idex_rd_i      = 5'd0;
    bus.ifid_rs2_i     = 5'd0;
    #1;
    check_outs("lu_x0", 5'b00000, 3'b000, 1'b0);
    next();
    check("lu_x0_cnt", bus.stall_cnt_o, 32'd1);
    // rs1 match
    bus.idex_rd_i  = 5'd7;
    bus.ifid_rs1_i = 5'd7;
    #1;
    check_outs("lu_rs1", 5'b11000, 3'b010, 1'b0);
    next();
    check("lu_rs1_cnt", bus.stall_cnt_o, 32'd2);
    // branch alone
    clear_inputs();
    bus.branch_taken_i = 1'b1;
    #1;
    check_outs("br", 5'b00000, 3'b100, 1'b0);
    next();
    check("br_cnt", bus.stall_cnt_o, 32'd2);
    clear_inputs();

    // 2. Single-ack memory access
    bus.exmem_mem_access_i = 1'b1;
    #1;
    check_outs("m1_c0", 5'b11111, 3'b001, 1'b0);
    next();
    bus.exmem_mem_access_i = 1'b0;
    bus.dmem_ack_i         = 1'b1;
    #1;
    check_outs("m1_c1", 5'b00000, 3'b000, 1'b1);
    next();
    bus.dmem_ack_i = 1'b0;
    #1;
    check_outs("m1_c2", 5'b00000, 3'b000, 1'b0);
    check("m1_cnt", bus.stall_cnt_o, 32'd3);

    // 3. Delayed ack: three wait cycles then ack
    reset_dut();
    bus.exmem_mem_access_i = 1'b1;
    #1;
    check_outs("m3_det", 5'b11111, 3'b001, 1'b0);
    next();
    bus.exmem_mem_access_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_outs("m3_wait", 5'b11111, 3'b001, 1'b1);
      next();
    end
    bus.dmem_ack_i = 1'b1;
    #1;
    check_outs("m3_ack", 5'b00000, 3'b000, 1'b1);
    next();
    bus.dmem_ack_i = 1'b0;
    #1;
    check_outs("m3_idle", 5'b00000, 3'b000, 1'b0);
    check("m3_cnt", bus.stall_cnt_o, 32'd4);
    check("m3_err", 32'(bus.error_o), 32'd0);

    // 4a. Load-use + branch: load-use wins, branch re-evaluated next cycle
    bus.idex_memread_i = 1'b1;
    bus.idex_rd_i      = 5'd3;
    bus.ifid_rs1_i     = 5'd3;
    bus.branch_taken_i = 1'b1;
    #1;
    check_outs("lu_br", 5'b11000, 3'b010, 1'b0);
    next();
    bus.idex_memread_i = 1'b0;
    #1;
    check_outs("br_after", 5'b00000, 3'b100, 1'b0);
    next();
    clear_inputs();

    // 4b. Mem access + load-use: only memory stall
    bus.exmem_mem_access_i = 1'b1;
    bus.idex_memread_i     = 1'b1;
    bus.idex_rd_i          = 5'd9;
    bus.ifid_rs2_i         = 5'd9;
    #1;
    check_outs("mem_lu", 5'b11111, 3'b001, 1'b0);
    next();
    bus.exmem_mem_access_i = 1'b0;
    bus.dmem_ack_i         = 1'b1;
    #1;
    check_outs("ack_lu", 5'b11000, 3'b010, 1'b1);
    next();
    clear_inputs();

    // 5. Timeout with MEM_TIMEOUT = 4
    reset_dut();
    bus.exmem_mem_access_i = 1'b1;
    next();
    bus.exmem_mem_access_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_outs("to_wait", 5'b11111, 3'b001, 1'b1);
      next();
      check("to_err", 32'(bus.error_o), (i == 3) ? 32'd1 : 32'd0);
    end
    check_outs("to_errst", 5'b11111, 3'b001, 1'b0);
    bus.dmem_ack_i = 1'b1;
    #1;
    check_outs("to_ack", 5'b11111, 3'b001, 1'b0);
    next();
    check("to_sticky", 32'(bus.error_o), 32'd1);
    check_outs("to_hold", 5'b11111, 3'b001, 1'b0);
    bus.dmem_ack_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("to_rst_err", 32'(bus.error_o), 32'd0);
    check_outs("to_rst", 5'b00000, 3'b000, 1'b0);
    check("to_rst_cnt", bus.stall_cnt_o, 32'd0);
    #1;
    rst_i = 1'b1;
    next();
    check_outs("to_idle", 5'b00000, 3'b000, 1'b0);

    // 6. Reset in the middle of MEM_REQ with an ack pending
    reset_dut();
    bus.exmem_mem_access_i = 1'b1;
    next();
    bus.exmem_mem_access_i = 1'b0;
    #1;
    check_outs("r6_req", 5'b11111, 3'b001, 1'b1);
    next();
    check("r6_cnt_pre", bus.stall_cnt_o, 32'd2);
    bus.dmem_ack_i         = 1'b1;
    bus.exmem_mem_access_i = 1'b1;
    #1;
    rst_i = 1'b0;
    #1;
    check_outs("r6_async", 5'b00000, 3'b000, 1'b0);
    check("r6_cnt", bus.stall_cnt_o, 32'd0);
    clear_inputs();
    #1;
    rst_i = 1'b1;
    next();
    check_outs("r6_idle", 5'b00000, 3'b000, 1'b0);
    bus.idex_memread_i = 1'b1;
    bus.idex_rd_i      = 5'd12;
    bus.ifid_rs1_i     = 5'd12;
    #1;
    check_outs("r6_lu", 5'b11000, 3'b010, 1'b0);
    next();
    check("r6_cnt_post", bus.stall_cnt_o, 32'd1);
    clear_inputs();
    next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
